// File: rtl/slow_down_counter.sv
// ---------------------------------------------------------------------------
// slow_down_counter
// Loadable down-counter that decrements once per prescaler tick. It has a
// small IDLE/RUN/PAUSE/DONE state machine and an optional wrap mode.
//
// Parameters
//   clk_half_period : clock half period in ns; prescaler length is
//                     cycles = 50_000 / clk_half_period (>= 1)
//   N               : width of the count output Q
//   WRAP            : 0 = stop at zero in DONE, 1 = wrap 0 -> 2^N-1 and run on
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   load       in   one-cycle load strobe
//   load_value in   [N] value copied into Q on load
//   enable     in   level: 1 = count, 0 = pause
//   Q          out  [N] current count (registered)
//   zero       out  registered, high whenever Q == 0
//   done       out  registered one-cycle pulse when Q reaches 0 by decrement
//   running    out  registered, high in state RUN only
// ---------------------------------------------------------------------------
module slow_down_counter #(
   parameter int unsigned clk_half_period = 10,
   parameter int unsigned N               = 2,
   parameter int unsigned WRAP            = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_value,
   input  logic         enable,
   output logic [N-1:0] Q,
   output logic         zero,
   output logic         done,
   output logic         running
);

   localparam int unsigned CYCLES = 50_000 / clk_half_period;
   localparam int unsigned PW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   localparam logic [PW-1:0] PRESC_RELOAD = PW'(CYCLES - 1);
   localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
   localparam logic [N-1:0]  Q_ONE        = N'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic [N-1:0]  q_next;
   logic          done_next;
   logic          count_en;
   logic          tick;
   logic          last_step;

   // The prescaler advances on every cycle where counting is enabled and no
   // load is pending. A PAUSE cycle with enable=1 is the resume edge and
   // counts like a RUN cycle, so a pause neither loses nor adds cycles.
   assign count_en  = ((state == RUN) || (state == PAUSE)) && enable && !load;
   assign tick      = count_en && (presc == '0);
   assign last_step = tick && (Q == Q_ONE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; load overrides everything except reset
   always_comb begin
      next_state = state;
      if (load) begin
         if ((load_value == '0) && (WRAP == 0)) begin
            next_state = DONE;
         end else if (enable) begin
            next_state = RUN;
         end else begin
            next_state = PAUSE;
         end
      end else begin
         case (state)
            IDLE: next_state = IDLE;
            RUN: begin
               if (!enable) begin
                  next_state = PAUSE;
               end else if (last_step && (WRAP == 0)) begin
                  next_state = DONE;
               end
            end
            PAUSE: begin
               if (enable) begin
                  if (last_step && (WRAP == 0)) begin
                     next_state = DONE;
                  end else begin
                     next_state = RUN;
                  end
               end
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Next values for count, prescaler and done pulse
   always_comb begin
      q_next     = Q;
      presc_next = presc;
      done_next  = 1'b0;
      if (load) begin
         q_next     = load_value;
         presc_next = PRESC_RELOAD;
      end else if (count_en) begin
         if (tick) begin
            presc_next = PRESC_RELOAD;
            q_next     = Q - Q_ONE;
            done_next  = last_step;
         end else begin
            presc_next = presc - PRESC_ONE;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= PRESC_RELOAD;
         Q       <= '0;
         zero    <= 1'b1;
         done    <= 1'b0;
         running <= 1'b0;
      end else begin
         presc   <= presc_next;
         Q       <= q_next;
         zero    <= (q_next == '0);
         done    <= done_next;
         running <= (next_state == RUN);
      end
   end

endmodule
